// File: rtl/rd_chk.sv
// Read-data checker: keeps a shadow copy of written data, checks returned
// read data against it after a fixed latency, and records mismatches.
module rd_chk #(
    parameter int DEPTH  = 16,
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wen,
    input  logic        ren,
    input  logic [63:0] wdin,
    input  logic [63:0] addr,
    input  logic [63:0] rdout,
    output logic        err_pulse,
    output logic [15:0] err_cnt,
    output logic [15:0] miss_cnt,
    output logic [15:0] ovf_cnt,
    output logic [31:0] wr_cnt,
    output logic [31:0] rd_cnt,
    output logic        full,
    output logic        err_vld,
    output logic [63:0] err_addr,
    output logic [63:0] err_exp,
    output logic [63:0] err_got
);

    localparam int IW = $clog2(DEPTH);

    logic [DEPTH-1:0] tbl_vld;
    logic [63:0]      tbl_addr [DEPTH];
    logic [63:0]      tbl_data [DEPTH];

    logic [DEPTH-1:0] hit_vec;
    logic             hit;
    logic [63:0]      hit_data;
    logic             free_ok;
    logic [IW-1:0]    free_idx;

    logic             pipe_vld  [RD_LAT];
    logic             pipe_hit  [RD_LAT];
    logic [63:0]      pipe_addr [RD_LAT];
    logic [63:0]      pipe_exp  [RD_LAT];

    logic             out_vld;
    logic             out_hit;
    logic             mismatch;

    // Associative lookup of addr against the table, plus lowest free slot
    always_comb begin
        hit_vec  = '0;
        hit_data = '0;
        free_ok  = 1'b0;
        free_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (tbl_vld[i] && (tbl_addr[i] == addr)) begin
                hit_vec[i] = 1'b1;
                hit_data   = hit_data | tbl_data[i];
            end
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!tbl_vld[i]) begin
                free_ok  = 1'b1;
                free_idx = IW'(i);
            end
        end
    end

    assign hit  = |hit_vec;
    assign full = &tbl_vld;

    // Valid bits only ever get set by an allocating write; reset clears them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tbl_vld <= '0;
        end else if (wen && !hit && free_ok) begin
            tbl_vld[free_idx] <= 1'b1;
        end
    end

    // Table payload: overwrite on hit, allocate on miss when a slot is free
    always_ff @(posedge clk) begin
        if (wen) begin
            if (hit) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (hit_vec[i]) tbl_data[i] <= wdin;
                end
            end else if (free_ok) begin
                tbl_addr[free_idx] <= addr;
                tbl_data[free_idx] <= wdin;
            end
        end
    end

    // Read pipeline carrying the pre-write lookup result to the compare stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_vld[i]  <= 1'b0;
                pipe_hit[i]  <= 1'b0;
                pipe_addr[i] <= '0;
                pipe_exp[i]  <= '0;
            end
        end else begin
            pipe_vld[0]  <= ren;
            pipe_hit[0]  <= hit;
            pipe_addr[0] <= addr;
            pipe_exp[0]  <= hit_data;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_hit[i]  <= pipe_hit[i-1];
                pipe_addr[i] <= pipe_addr[i-1];
                pipe_exp[i]  <= pipe_exp[i-1];
            end
        end
    end

    assign out_vld  = pipe_vld[RD_LAT-1];
    assign out_hit  = pipe_hit[RD_LAT-1];
    assign mismatch = out_vld && out_hit && (rdout != pipe_exp[RD_LAT-1]);

    // Saturating statistics and the per-mismatch pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_pulse <= 1'b0;
            err_cnt   <= '0;
            miss_cnt  <= '0;
            ovf_cnt   <= '0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
        end else begin
            err_pulse <= mismatch;
            if (mismatch && (err_cnt != '1)) err_cnt <= err_cnt + 16'd1;
            if (out_vld && !out_hit && (miss_cnt != '1)) miss_cnt <= miss_cnt + 16'd1;
            if (out_vld && (rd_cnt != '1)) rd_cnt <= rd_cnt + 32'd1;
            if (wen && (wr_cnt != '1)) wr_cnt <= wr_cnt + 32'd1;
            if (wen && !hit && !free_ok && (ovf_cnt != '1)) ovf_cnt <= ovf_cnt + 16'd1;
        end
    end

    // Capture details of the first mismatch only; sticky until reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_vld  <= 1'b0;
            err_addr <= '0;
            err_exp  <= '0;
            err_got  <= '0;
        end else if (mismatch && !err_vld) begin
            err_vld  <= 1'b1;
            err_addr <= pipe_addr[RD_LAT-1];
            err_exp  <= pipe_exp[RD_LAT-1];
            err_got  <= rdout;
        end
    end

endmodule

// File: tb/tb_rd_chk.sv
// Self-checking bench for rd_chk: directed scenarios plus random traffic,
// checked every cycle against a map/queue reference model.
module tb_rd_chk;

    localparam int DEPTH  = 4;
    localparam int RD_LAT = 3;

    logic        clk;
    logic        rst_n;
    logic        wen;
    logic        ren;
    logic [63:0] wdin;
    logic [63:0] addr;
    logic [63:0] rdout;
    logic        err_pulse;
    logic [15:0] err_cnt;
    logic [15:0] miss_cnt;
    logic [15:0] ovf_cnt;
    logic [31:0] wr_cnt;
    logic [31:0] rd_cnt;
    logic        full;
    logic        err_vld;
    logic [63:0] err_addr;
    logic [63:0] err_exp;
    logic [63:0] err_got;

    rd_chk #(.DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wen       (wen),
        .ren       (ren),
        .wdin      (wdin),
        .addr      (addr),
        .rdout     (rdout),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt),
        .miss_cnt  (miss_cnt),
        .ovf_cnt   (ovf_cnt),
        .wr_cnt    (wr_cnt),
        .rd_cnt    (rd_cnt),
        .full      (full),
        .err_vld   (err_vld),
        .err_addr  (err_addr),
        .err_exp   (err_exp),
        .err_got   (err_got)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          due;
        bit          hit;
        logic [63:0] addr;
        logic [63:0] exp;
        logic [63:0] rsp;
    } rd_t;

    rd_t         pend [$];
    logic [63:0] shadow [logic [63:0]];
    int          cyc;

    bit          m_err_pulse;
    bit          m_err_vld;
    int          m_err_cnt;
    int          m_miss_cnt;
    int          m_ovf_cnt;
    longint      m_wr_cnt;
    longint      m_rd_cnt;
    logic [63:0] m_err_addr;
    logic [63:0] m_err_exp;
    logic [63:0] m_err_got;

    int n_checks;
    int n_fail;

    task automatic check64(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic checkOutput();
        check64("err_pulse", 64'(err_pulse), 64'(m_err_pulse));
        check64("err_cnt",   64'(err_cnt),   64'(m_err_cnt));
        check64("miss_cnt",  64'(miss_cnt),  64'(m_miss_cnt));
        check64("ovf_cnt",   64'(ovf_cnt),   64'(m_ovf_cnt));
        check64("wr_cnt",    64'(wr_cnt),    64'(m_wr_cnt));
        check64("rd_cnt",    64'(rd_cnt),    64'(m_rd_cnt));
        check64("full",      64'(full),      64'(shadow.num() == DEPTH));
        check64("err_vld",   64'(err_vld),   64'(m_err_vld));
        check64("err_addr",  err_addr,       m_err_addr);
        check64("err_exp",   err_exp,        m_err_exp);
        check64("err_got",   err_got,        m_err_got);
    endtask

    task automatic model_reset();
        pend.delete();
        shadow.delete();
        m_err_pulse = 0;
        m_err_vld   = 0;
        m_err_cnt   = 0;
        m_miss_cnt  = 0;
        m_ovf_cnt   = 0;
        m_wr_cnt    = 0;
        m_rd_cnt    = 0;
        m_err_addr  = '0;
        m_err_exp   = '0;
        m_err_got   = '0;
    endtask

    // One clock cycle of traffic; rsp is what the responder returns RD_LAT later
    task automatic applyStimulus(input bit w, input bit r, input logic [63:0] wd,
                                 input logic [63:0] ad, input logic [63:0] rsp);
        rd_t e;
        rd_t o;
        bit  retire;
        wen  = w;
        ren  = r;
        wdin = wd;
        addr = ad;
        retire = (pend.size() > 0) && (pend[0].due == cyc);
        if (retire) rdout = pend[0].rsp;
        else        rdout = {$urandom, $urandom};
        @(posedge clk);
        m_err_pulse = 0;
        if (retire) begin
            o = pend.pop_front();
            if (m_rd_cnt < 64'hFFFF_FFFF) m_rd_cnt++;
            if (!o.hit) begin
                if (m_miss_cnt < 65535) m_miss_cnt++;
            end else if (o.rsp !== o.exp) begin
                m_err_pulse = 1;
                if (m_err_cnt < 65535) m_err_cnt++;
                if (!m_err_vld) begin
                    m_err_vld  = 1;
                    m_err_addr = o.addr;
                    m_err_exp  = o.exp;
                    m_err_got  = o.rsp;
                end
            end
        end
        if (r) begin
            e.due  = cyc + RD_LAT;
            e.hit  = shadow.exists(ad);
            e.addr = ad;
            e.exp  = e.hit ? shadow[ad] : 64'h0;
            e.rsp  = rsp;
            pend.push_back(e);
        end
        if (w) begin
            if (m_wr_cnt < 64'hFFFF_FFFF) m_wr_cnt++;
            if (shadow.exists(ad) || (shadow.num() < DEPTH)) shadow[ad] = wd;
            else if (m_ovf_cnt < 65535) m_ovf_cnt++;
        end
        cyc++;
        @(negedge clk);
        checkOutput();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 64'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        wen   = 1'b0;
        ren   = 1'b0;
        #1;
        model_reset();
        checkOutput();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput();
    endtask

    // Directed scenarios followed by random traffic and a saturation run
    initial begin
        logic [63:0] a;
        logic [63:0] d;
        logic [63:0] exp;
        bit          w;
        bit          r;
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        rst_n    = 1'b0;
        wen      = 1'b0;
        ren      = 1'b0;
        wdin     = '0;
        addr     = '0;
        rdout    = '0;
        model_reset();
        #12;
        checkOutput();
        @(negedge clk);
        rst_n = 1'b1;

        // Matching read
        applyStimulus(1, 0, 64'hA5A5, 64'h10, 0);
        applyStimulus(0, 1, 64'h0, 64'h10, 64'hA5A5);
        idle(RD_LAT + 1);
        check64("rd_cnt_match", 64'(rd_cnt), 64'd1);
        check64("err_cnt_match", 64'(err_cnt), 64'd0);

        // Mismatch then a second mismatch that must not overwrite capture
        applyStimulus(1, 0, 64'h1, 64'h20, 0);
        applyStimulus(0, 1, 64'h0, 64'h20, 64'h2);
        idle(RD_LAT + 1);
        check64("err_addr_first", err_addr, 64'h20);
        check64("err_got_first", err_got, 64'h2);
        applyStimulus(0, 1, 64'h0, 64'h20, 64'h3);
        idle(RD_LAT + 1);
        check64("err_cnt_two", 64'(err_cnt), 64'd2);
        check64("err_got_kept", err_got, 64'h2);

        // Read-before-write on the same address
        applyStimulus(1, 0, 64'h5, 64'h30, 0);
        applyStimulus(1, 1, 64'h6, 64'h30, 64'h5);
        applyStimulus(0, 1, 64'h0, 64'h30, 64'h6);
        idle(RD_LAT + 1);
        check64("err_cnt_rbw", 64'(err_cnt), 64'd2);

        // Fill the table and overflow it, then read the dropped address
        do_reset();
        for (int i = 0; i <= DEPTH; i++)
            applyStimulus(1, 0, 64'(i + 100), 64'h100 + 64'(i * 8), 0);
        check64("ovf_cnt_full", 64'(ovf_cnt), 64'd1);
        check64("full_set", 64'(full), 64'd1);
        applyStimulus(0, 1, 64'h0, 64'h100 + 64'(DEPTH * 8), 64'hDEAD);
        idle(RD_LAT + 1);
        check64("miss_cnt_drop", 64'(miss_cnt), 64'd1);

        // Reset with reads in flight
        do_reset();
        applyStimulus(1, 0, 64'h9, 64'h50, 0);
        applyStimulus(0, 1, 64'h0, 64'h50, 64'h0);
        idle(RD_LAT + 1);
        applyStimulus(0, 1, 64'h0, 64'h50, 64'h0);
        applyStimulus(0, 1, 64'h0, 64'h50, 64'h0);
        rst_n = 1'b0;
        #1;
        model_reset();
        checkOutput();
        ren = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            checkOutput();
        end
        ren   = 1'b0;
        rst_n = 1'b1;
        idle(RD_LAT + 2);
        check64("rd_cnt_after_rst", 64'(rd_cnt), 64'd0);

        // Random traffic over a small address pool
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) a = {$urandom, $urandom};
            else a = 64'h1000 + 64'($urandom_range(0, 6)) * 8;
            d = {$urandom, $urandom};
            w = ($urandom_range(0, 2) == 0);
            r = ($urandom_range(0, 1) == 0);
            exp = shadow.exists(a) ? shadow[a] : 64'h0;
            if ($urandom_range(0, 3) != 0) d = d;
            applyStimulus(w, r, d, a,
                          ($urandom_range(0, 3) != 0) ? exp : (exp ^ {$urandom, $urandom | 32'h1}));
        end
        idle(RD_LAT + 1);

        // Error counter saturation under continuous mismatching reads
        do_reset();
        applyStimulus(1, 0, 64'h7, 64'h40, 0);
        for (int i = 0; i < 65540; i++)
            applyStimulus(0, 1, 64'h0, 64'h40, 64'h8);
        check64("err_cnt_sat", 64'(err_cnt), 64'hFFFF);
        check64("err_pulse_sat", 64'(err_pulse), 64'd1);
        idle(RD_LAT + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
